// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampled UART receiver with majority voting, parity/framing/break/overrun
// reporting and a valid/ack holding register toward the consumer.
module uart_rx_ext #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SB_TICK     = 16,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  receiver_in,
    input  logic                  s_tick,
    input  logic                  rx_ack,
    output logic                  receiver_done_tick,
    output logic [DATA_WIDTH-1:0] receiver_data_out,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun_err
);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int SW   = $clog2(SB_TICK);
    localparam int NW   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [SW-1:0]           s_q, s_d;
    logic [NW-1:0]           n_q, n_d;
    logic [1:0]              hist_q;
    logic [DATA_WIDTH-1:0]   sh_q, sh_d, data_q;
    logic                    par_q, par_d, stop_q, stop_d, hold_q, hold_d, done_q, done_d;
    logic                    valid_q, pe_q, fe_q, brk_q, ovr_q;
    logic                    rxs, maj, stop_bit, pe, fe, brk, accept;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign maj      = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
    assign stop_bit = (s_q == SW'(OVERSAMPLE-1)) ? maj : stop_q;
    assign pe       = (PARITY_EN != 0) && ((^{sh_q, par_q}) != (PARITY_ODD != 0));
    assign fe       = ~stop_q;
    assign brk      = fe & ~|sh_q & ((PARITY_EN == 0) | ~par_q);
    assign accept   = done_q & (~valid_q | rx_ack);

    // hold_q keeps a line stuck low after a framing error from re-triggering a start
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        par_d   = par_q;
        stop_d  = stop_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = hold_q & ~rxs;
                if (~rxs && ~hold_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: if (s_tick) begin
                if (s_q == SW'(HALF-1)) begin
                    state_d = maj ? IDLE : DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else s_d = s_q + 1'b1;
            end
            DATA: if (s_tick) begin
                if (s_q == SW'(OVERSAMPLE-1)) begin
                    sh_d = {maj, sh_q[DATA_WIDTH-1:1]};
                    s_d  = '0;
                    n_d  = n_q + 1'b1;
                    if (n_q == NW'(DATA_WIDTH-1)) state_d = (PARITY_EN != 0) ? PAR : STOP;
                end else s_d = s_q + 1'b1;
            end
            PAR: if (s_tick) begin
                if (s_q == SW'(OVERSAMPLE-1)) begin
                    par_d   = maj;
                    s_d     = '0;
                    state_d = STOP;
                end else s_d = s_q + 1'b1;
            end
            STOP: if (s_tick) begin
                if (s_q == SW'(OVERSAMPLE-1)) stop_d = maj;
                if (s_q == SW'(SB_TICK-1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    hold_d  = ~stop_bit;
                    s_d     = '0;
                end else s_d = s_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            sync_q  <= '1;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            hist_q  <= 2'b11;
            sh_q    <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], receiver_in};
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            if (s_tick) hist_q <= {hist_q[0], rxs};
            sh_q    <= sh_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            // frame results are committed at the end of the cycle the done pulse is visible
            if (accept) begin
                data_q <= sh_q;
                pe_q   <= pe;
                fe_q   <= fe;
                brk_q  <= brk;
            end
            valid_q <= accept | (valid_q & ~rx_ack);
            ovr_q   <= ovr_q | (done_q & valid_q & ~rx_ack);
        end
    end

    assign receiver_done_tick = done_q;
    assign receiver_data_out  = data_q;
    assign rx_valid           = valid_q;
    assign parity_err         = pe_q;
    assign frame_err          = fe_q;
    assign break_det          = brk_q;
    assign overrun_err        = ovr_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed and randomized frames on an 8E1 receiver, checked against a frame-level model.
module tb_uart_rx_ext;
    localparam int P = 4, OS = 16, DW = 8, LAT = 8 + 10 * OS;

    logic clk = 0, reset_in = 1, receiver_in = 1, s_tick = 0, rx_ack = 0;
    logic receiver_done_tick, rx_valid, parity_err, frame_err, break_det, overrun_err;
    logic [DW-1:0] receiver_data_out;
    int tests = 0, fails = 0, done_total = 0, exp_done = 0, tcnt = 0, lat_ticks;
    logic [DW-1:0] e_data;
    logic e_valid, e_pe, e_fe, e_brk, e_ovr, ack_on_done = 0;

    uart_rx_ext #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .SB_TICK(16), .PARITY_EN(1),
                  .PARITY_ODD(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_in(reset_in), .receiver_in(receiver_in), .s_tick(s_tick),
        .rx_ack(rx_ack), .receiver_done_tick(receiver_done_tick),
        .receiver_data_out(receiver_data_out), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .break_det(break_det), .overrun_err(overrun_err));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcnt   <= (tcnt == P - 1) ? 0 : tcnt + 1;
        s_tick <= (tcnt == P - 1);
    end

    always @(negedge clk) if (receiver_done_tick) done_total <= done_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".data"}, receiver_data_out, e_data);
        check({tag, ".valid"}, rx_valid, e_valid);
        check({tag, ".flags"}, {parity_err, frame_err, break_det}, {e_pe, e_fe, e_brk});
        check({tag, ".ovr"}, overrun_err, e_ovr);
        check({tag, ".dones"}, done_total, exp_done);
    endtask

    task automatic model_reset();
        e_data = '0; e_valid = 0; e_pe = 0; e_fe = 0; e_brk = 0; e_ovr = 0;
    endtask

    task automatic model_frame(input logic [DW-1:0] d, input logic par, input logic stop, input logic ackd);
        exp_done++;
        if (!e_valid || ackd) begin
            e_data  = d;
            e_pe    = (^d) ^ par;
            e_fe    = ~stop;
            e_brk   = ~stop && d == 0 && !par;
            e_valid = 1;
        end else e_ovr = 1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!s_tick) @(negedge clk);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic par, input logic stop, input int glitch);
        receiver_in = 0;
        ticks(OS);
        for (int i = 0; i < DW; i++) begin
            receiver_in = d[i];
            if (i == glitch) begin
                ticks(OS / 2 - 2);
                receiver_in = 0;
                ticks(1);
                receiver_in = 1;
                ticks(OS / 2 + 1);
            end else ticks(OS);
        end
        receiver_in = par;
        ticks(OS);
        receiver_in = stop;
        ticks(OS);
        receiver_in = 1;
    endtask

    task automatic watch(output int n);
        int c = 0;
        n = -1;
        for (int k = 0; k < P * OS * 14; k++) begin
            @(negedge clk);
            if (receiver_done_tick) begin
                n = c;
                if (ack_on_done) begin
                    rx_ack = 1;
                    @(negedge clk);
                    rx_ack = 0;
                end
                break;
            end
            if (s_tick) c++;
        end
    endtask

    task automatic frame(input string tag, input logic [DW-1:0] d, input logic par,
                         input logic stop, input int glitch, input logic ackd);
        ack_on_done = ackd;
        fork
            send(d, par, stop, glitch);
            watch(lat_ticks);
        join
        ack_on_done = 0;
        check({tag, ".lat"}, lat_ticks, LAT);
        model_frame(d, par, stop, ackd);
        check_outs(tag);
    endtask

    task automatic ack();
        @(negedge clk) rx_ack = 1;
        @(negedge clk) rx_ack = 0;
        e_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset_in = 1;
        @(negedge clk) reset_in = 0;
        model_reset();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic par, stop;
        int g, mode, gap;
        model_reset();
        repeat (3) @(negedge clk);
        reset_in = 0;
        check_outs("reset");
        ticks(4);
        frame("a5", 8'hA5, 1'b0, 1'b1, -1, 1'b0);
        ack();
        check("a5.ack", rx_valid, 1'b0);
        ticks(4);
        frame("par_bad", 8'h07, 1'b0, 1'b1, -1, 1'b0);
        ack();
        ticks(4);
        frame("par_ok", 8'h07, 1'b1, 1'b1, -1, 1'b0);
        ack();
        ticks(4);
        receiver_in = 0;
        ticks(4);
        receiver_in = 1;
        ticks(40);
        check_outs("false_start");
        frame("spike", 8'hFF, 1'b0, 1'b1, 3, 1'b0);
        ack();
        ticks(4);
        fork
            begin
                receiver_in = 0;
                ticks(12 * OS);
                receiver_in = 1;
            end
            watch(lat_ticks);
        join
        check("brk.lat", lat_ticks, LAT);
        model_frame('0, 1'b0, 1'b0, 1'b0);
        ticks(3 * OS);
        check_outs("brk");
        ack();
        ticks(4);
        frame("after_brk", 8'h5A, 1'b0, 1'b1, -1, 1'b0);
        do_reset();
        ticks(2);
        frame("ovr1", 8'h11, 1'b0, 1'b1, -1, 1'b0);
        frame("ovr2", 8'h22, 1'b0, 1'b1, -1, 1'b0);
        do_reset();
        ticks(2);
        frame("ackd1", 8'h11, 1'b0, 1'b1, -1, 1'b0);
        frame("ackd2", 8'h22, 1'b0, 1'b1, -1, 1'b1);
        ticks(2);
        fork
            send(8'hFF, 1'b1, 1'b1, -1);
            begin
                ticks(3 * OS + 5);
                do_reset();
                @(negedge clk);
                check_outs("mid_rst");
            end
        join
        ticks(2 * OS);
        check_outs("post_rst");
        frame("3c", 8'h3C, 1'b0, 1'b1, -1, 1'b0);
        ack();
        ticks(3);
        for (int k = 0; k < 30; k++) begin
            d    = DW'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = $urandom_range(0, 7) != 0;
            g    = $urandom_range(0, DW - 1);
            if (!d[g] || $urandom_range(0, 1) == 0) g = -1;
            mode = $urandom_range(0, 2);
            frame("rnd", d, par, stop, g, mode == 2);
            if (mode == 1) begin
                ack();
                check("rnd.ack", rx_valid, 1'b0);
            end
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            if ((mode == 1 || !stop) && gap < 2) gap = 2;
            ticks(gap);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised next-generation UART receiver. Oversampled by an external baud tick (s_tick). Adds:
- configurable data width, parity and stop length;
- input synchroniser, 3-sample majority voting and false-start rejection;
- parity, framing, break and overrun reporting;
- a valid/ack holding register toward the consumer.

Sits between the pad-side serial line and the receive FIFO or register file. Shares the baud generator with the transmitter.

Parameters:
- DATA_WIDTH, 8, data bits per frame, legal 5..9, LSB first.
- OVERSAMPLE, 16, s_tick pulses per bit, even, at least 8.
- SB_TICK, 16, s_ticks spent in STOP counted from the last data/parity mid-point. Use 16/24/32 for 1/1.5/2 stop bits. Must be at least OVERSAMPLE.
- PARITY_EN, 0, 1 = a parity bit follows the data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- SYNC_STAGES, 2, synchroniser flops on receiver_in, at least 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_in  in  1  synchronous reset, active-high.
- receiver_in  in  1  asynchronous serial line, idle high.
- s_tick  in  1  one-clk oversample strobe.
- rx_ack  in  1  consumer has taken receiver_data_out; clears rx_valid.
- receiver_done_tick  out  1  one-clk pulse at frame completion (good or bad).
- receiver_data_out  out  DATA_WIDTH  last accepted frame data.
- rx_valid  out  1  receiver_data_out holds unread data.
- parity_err  out  1  parity mismatch in last accepted frame.
- frame_err  out  1  stop bit sampled low in last accepted frame.
- break_det  out  1  last frame was all-zero data with stop low.
- overrun_err  out  1  sticky; a frame completed while rx_valid=1.

Behaviour:
Reset:
- Synchroniser flops load 1.
- State IDLE, counters 0.
- All outputs 0.
- Reset asserted mid-frame abandons the frame with no done pulse.

Timing:
- rxs is the synchronised line. Latency from pin to rxs is SYNC_STAGES clks.
- s counter: width clog2(SB_TICK). Increments only on s_tick.
- n counter: counts received data bits.
- HALF = OVERSAMPLE/2.
- Majority: a bit value is the majority of rxs captured on three consecutive s_ticks. The bit decision is made on the third of those ticks.

State machine:
- IDLE: when rxs=0, go to START with s=0. s_tick is not required for this transition.
- START: samples are taken at s=HALF-3..HALF-1 and decided at s=HALF-1.
  - Majority 1: false start; return to IDLE with no output.
  - Majority 0: go to DATA with s=0, n=0.
- DATA: samples are taken at s=OVERSAMPLE-3..OVERSAMPLE-1 and decided at s=OVERSAMPLE-1.
  - Shift the bit into the MSB of the shift register (LSB-first), then s=0.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: same sampling as DATA. Store the parity bit, s=0, go to STOP.
- STOP: stop bit is the majority at s=OVERSAMPLE-3..OVERSAMPLE-1. At s=SB_TICK-1:
  - pulse receiver_done_tick for one clk;
  - go to IDLE.

Completion (in the done cycle):
- Error computation:
  - pe = PARITY_EN & (XOR(data,parity) != PARITY_ODD).
  - fe = ~stop.
  - brk = fe & (data==0) & (parity bit==0 or PARITY_EN=0).
- If rx_valid=0, or rx_ack=1 in the same cycle:
  - load receiver_data_out, parity_err, frame_err and break_det;
  - rx_valid stays or becomes 1.
- Else: discard the new frame, set overrun_err, keep the old data and flags.
- Frames with errors are still delivered. Flags are held until the next accepted frame.

Handshake and flags:
- rx_ack with rx_valid=1 clears rx_valid next clk.
- rx_ack with rx_valid=0 is ignored.
- overrun_err is cleared only by reset_in.
- Outputs are registered. No combinational path exists from receiver_in or rx_ack to any output.
- The next start bit is accepted the clk after returning to IDLE. Back-to-back frames with no idle gap must be received.

Test Plan:
1. OVERSAMPLE=16, 8N1, send 0xA5 -> one done pulse. receiver_data_out=0xA5, rx_valid=1, parity_err, frame_err and break_det all 0. Done occurs 8+9*16 s_ticks after the falling start edge, plus the SYNC_STAGES-clk pin-to-rxs latency.
2. PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1, data 0x07. The same frame with parity 1 -> parity_err=0.
3. Low glitch of 4 s_ticks on idle line -> no done pulse, rx_valid stays 0. Single-tick low spike at a data-bit mid-point of 0xFF -> data still 0xFF.
4. Line held low 12 bit-times -> frame_err=1, break_det=1, data 0x00. No further frame until the line returns high then falls again.
5. Two frames 0x11 then 0x22, no rx_ack -> data stays 0x11 and overrun_err=1. rx_ack asserted on the second done cycle -> data 0x22, overrun_err stays 0.
6. reset_in for 1 clk in the middle of DATA -> all outputs 0, no done. The next complete frame 0x3C is received correctly.
